// File: rtl/div_pkg.sv
// Shared width, step count, FSM encoding and sign helper for the sequential divider.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_divider_if;
    import div_pkg::*;

    // start is a one-cycle request taken only while busy=0 and result_ready=0;
    // there is no backpressure, a request made otherwise is dropped. result_ready
    // is a one-cycle valid for quotient/remainder/exception with no ready return.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             result_ready;
    logic             exception;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, result_ready, exception
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, result_ready, exception
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step
    import div_pkg::*;
(
    input  logic [WIDTH:0]   rem_i,
    input  logic             shift_in_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder stays below the divisor, so its top bit only acts as a guard.
    assign shifted = {rem_i[WIDTH-1:0], shift_in_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit_o = rem_i[WIDTH] | ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/seq_divider.sv
// 32-bit signed sequential divider: magnitudes through 32 restoring steps, signs fixed on the way into DONE.
module seq_divider
    import div_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    seq_divider_if.slave div_if,
    output state_e       dbg_state_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             q_sign_q, q_sign_d;
    logic             r_sign_q, r_sign_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exception_q, exception_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_shift;

    // a_q holds the dividend magnitude on entry and fills with quotient bits from the bottom.
    div_step u_step (
        .rem_i      (p_q),
        .shift_in_i (a_q[WIDTH-1]),
        .divisor_i  (b_q),
        .rem_o      (step_rem),
        .q_bit_o    (step_q)
    );

    assign q_shift = {a_q[WIDTH-2:0], step_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        a_d         = a_q;
        p_d         = p_q;
        b_d         = b_q;
        q_sign_d    = q_sign_q;
        r_sign_d    = r_sign_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        exception_d = exception_q;

        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    a_d      = negate_if(div_if.dividend, div_if.dividend[WIDTH-1]);
                    b_d      = negate_if(div_if.divisor, div_if.divisor[WIDTH-1]);
                    q_sign_d = div_if.dividend[WIDTH-1] ^ div_if.divisor[WIDTH-1];
                    r_sign_d = div_if.dividend[WIDTH-1];
                    dz_d     = (div_if.divisor == '0);
                    p_d      = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (dz_q) begin
                    quotient_d  = '0;
                    remainder_d = negate_if(a_q, r_sign_q);
                    exception_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    p_d     = step_rem;
                    a_d     = q_shift;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(STEPS - 1)) begin
                        quotient_d  = negate_if(q_shift, q_sign_q);
                        remainder_d = negate_if(step_rem[WIDTH-1:0], r_sign_q);
                        exception_d = 1'b0;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            a_q         <= '0;
            p_q         <= '0;
            b_q         <= '0;
            q_sign_q    <= 1'b0;
            r_sign_q    <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            a_q         <= a_d;
            p_q         <= p_d;
            b_q         <= b_d;
            q_sign_q    <= q_sign_d;
            r_sign_q    <= r_sign_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            exception_q <= exception_d;
        end
    end

    assign div_if.quotient     = quotient_q;
    assign div_if.remainder    = remainder_q;
    assign div_if.exception    = exception_q;
    assign div_if.busy         = (state_q == RUN);
    assign div_if.result_ready = (state_q == DONE);
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus ignored-start, hold and mid-run reset sequences.
module tb_seq_divider;
    import div_pkg::*;

    logic   clock;
    logic   reset_n;
    state_e dbg_state;

    seq_divider_if div_if();

    seq_divider dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .div_if      (div_if),
        .dbg_state_o (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one division and wait for its result. inj >= 0 drives a second
    // start (9/3) while the first is running; done_start drives one during DONE.
    task automatic run_div(input string name, input logic [31:0] dd, input logic [31:0] dv,
                           input logic [31:0] eq, input logic [31:0] er, input logic ee,
                           input int elat, input int inj, input bit done_start);
        int k;
        int busy_cycles;
        logic [63:0] exp;
        @(negedge clock);
        div_if.start    = 1'b1;
        div_if.dividend = dd;
        div_if.divisor  = dv;
        exp_q.push_back({eq, er});
        @(negedge clock);
        div_if.start = 1'b0;
        k = 0;
        busy_cycles = 0;
        while (div_if.result_ready !== 1'b1 && k < 64) begin
            if (div_if.busy === 1'b1) busy_cycles++;
            if (k == inj) begin
                div_if.start    = 1'b1;
                div_if.dividend = 32'd9;
                div_if.divisor  = 32'd3;
            end else begin
                div_if.start = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        div_if.start = 1'b0;
        exp = exp_q.pop_front();
        if (k >= 64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no result_ready within 64 cycles expected one at %0d", name, elat);
        end else begin
            check({name, "_latency"}, 32'(k), 32'(elat));
            check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(elat));
            check({name, "_quotient"}, div_if.quotient, exp[63:32]);
            check({name, "_remainder"}, div_if.remainder, exp[31:0]);
            check({name, "_exception"}, 32'(div_if.exception), 32'(ee));
            check({name, "_busy_in_done"}, 32'(div_if.busy), 32'd0);
            if (done_start) begin
                div_if.start    = 1'b1;
                div_if.dividend = 32'd9;
                div_if.divisor  = 32'd3;
            end
            @(negedge clock);
            div_if.start = 1'b0;
            check({name, "_ready_pulse"}, 32'(div_if.result_ready), 32'd0);
            check({name, "_busy_after_done"}, 32'(div_if.busy), 32'd0);
        end
    endtask

    initial begin
        int pulses;

        vecs[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32};
        vecs[1]  = '{-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 32};
        vecs[2]  = '{32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 32};
        vecs[3]  = '{-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 32};
        vecs[4]  = '{32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1};
        vecs[5]  = '{-32'sd5, 32'd0, 32'd0, -32'sd5, 1'b1, 1};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 32};
        vecs[7]  = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 32};
        vecs[8]  = '{32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 32};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 32};
        vecs[10] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 32};
        vecs[11] = '{32'd1000000, -32'sd3, -32'sd333333, 32'd1, 1'b0, 32};
        vecs[12] = '{-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 32};

        reset_n         = 1'b0;
        div_if.start    = 1'b0;
        div_if.dividend = '0;
        div_if.divisor  = '0;

        #12;
        check("reset_quotient", div_if.quotient, 32'd0);
        check("reset_remainder", div_if.remainder, 32'd0);
        check("reset_busy", 32'(div_if.busy), 32'd0);
        check("reset_result_ready", 32'(div_if.result_ready), 32'd0);
        check("reset_exception", 32'(div_if.exception), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].q, vecs[i].r,
                    vecs[i].exc, vecs[i].lat, -1, 1'b0);
        end

        // Exception flag holds after a divide-by-zero until the next DONE.
        run_div("dz_hold", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1, -1, 1'b0);
        repeat (3) @(negedge clock);
        check("dz_hold_exception", 32'(div_if.exception), 32'd1);

        // Second start sampled at E+10 is dropped; a start during DONE is dropped too.
        run_div("ignored_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 9, 1'b1);
        repeat (5) @(negedge clock);
        check("hold_quotient", div_if.quotient, 32'd14);
        check("hold_remainder", div_if.remainder, 32'd2);
        check("hold_ready_low", 32'(div_if.result_ready), 32'd0);
        check("hold_busy_low", 32'(div_if.busy), 32'd0);

        // Asynchronous reset at E+15 aborts the division.
        @(negedge clock);
        div_if.start    = 1'b1;
        div_if.dividend = 32'd100;
        div_if.divisor  = 32'd7;
        @(negedge clock);
        div_if.start = 1'b0;
        repeat (15) @(negedge clock);
        check("abort_busy_before", 32'(div_if.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_quotient", div_if.quotient, 32'd0);
        check("abort_remainder", div_if.remainder, 32'd0);
        check("abort_busy", 32'(div_if.busy), 32'd0);
        check("abort_result_ready", 32'(div_if.result_ready), 32'd0);
        check("abort_exception", 32'(div_if.exception), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (div_if.result_ready === 1'b1) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);
        run_div("after_abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is supported.
REQ-002 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  one-cycle request; operands sampled on the same edge.
REQ-005 Port: dividend  input  32  signed two's-complement numerator.
REQ-006 Port: divisor  input  32  signed two's-complement denominator.
REQ-007 Port: quotient  output  32  signed quotient, truncated toward zero.
REQ-008 Port: remainder  output  32  signed remainder, same sign as dividend.
REQ-009 Port: busy  output  1  high while a division is in progress.
REQ-010 Port: result_ready  output  1  one-cycle pulse; quotient/remainder/exception valid.
REQ-011 Port: exception  output  1  divide-by-zero flag, valid with result_ready.

Function
REQ-012 States: IDLE, RUN, DONE; encoding 2 bits.
REQ-013 IDLE + start at edge E: latch |dividend|, |divisor|, result sign (XOR of operand signs), remainder sign (dividend sign); clear 33-bit partial remainder; count=0; go RUN; busy=1.
REQ-014 RUN: one restoring step per edge: shift {partial remainder, quotient} left 1, subtract divisor magnitude (33-bit), keep difference and set quotient LSB=1 if non-negative, else restore and LSB=0.
REQ-015 RUN: count increments each edge; after 32nd step (edge E+32) go DONE.
REQ-016 DONE: lasts exactly one cycle (between edges E+32 and E+33); result_ready=1, busy=0; then IDLE.
REQ-017 Sign correction: quotient negated (two's complement) if result sign=1; remainder negated if remainder sign=1; applied when entering DONE so outputs are registered.
REQ-018 Divisor==0 at start: skip RUN; DONE at edge E+1; exception=1, quotient=0, remainder=dividend.
REQ-019 Overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, exception=0 (wraps, no flag).
REQ-020 start while busy (RUN) or in DONE: ignored; operands not resampled.
REQ-021 quotient, remainder, exception hold their last values from DONE until the next DONE.
REQ-022 exception=0 for every non-zero divisor.

Reset
REQ-023 reset_n low: state=IDLE, count=0, quotient=0, remainder=0, busy=0, result_ready=0, exception=0, immediately (asynchronous).
REQ-024 Reset mid-RUN aborts the division; no result_ready pulse follows; first start after release operates normally.

Structure
REQ-025 Shared package/header div_pkg: WIDTH, state encodings IDLE/RUN/DONE, step count 32.
REQ-026 One sub-module div_step: combinational 33-bit subtract-and-select (inputs partial remainder, divisor magnitude; outputs next remainder, quotient bit); FSM, counter, sign handling stay in seq_divider.

Verification
REQ-027 100 / 7, start at edge E -> result_ready high only between E+32 and E+33; quotient=14, remainder=2, exception=0.
REQ-028 -100 / 7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); 100 / -7 -> quotient=-14, remainder=2.
REQ-029 5 / 0 -> result_ready between E+1 and E+2, exception=1, quotient=0, remainder=5; busy never 1 for more than one cycle.
REQ-030 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, exception=0; 7 / 100 -> quotient=0, remainder=7.
REQ-031 start 100/7, second start with 9/3 at E+10 -> ignored; result 14 r 2 at E+32; outputs held until next start.
REQ-032 reset_n low at E+15 of a division -> all outputs 0 at once, no result_ready; new start 9/3 after release -> quotient=3, remainder=0 after 32 cycles.
